// File: rtl/wisc_pipe_pkg.sv
// Shared pipeline-control types: sequencer states, register width, stage control bundle.
package wisc_pipe_pkg;

    localparam int REG_W = 4;

    // Instruction word the datapath loads into a flushed/bubbled pipeline register.
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        D_FILL = 2'd1,
        I_FILL = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic mem_wb_write;
        logic if_id_flush;
        logic id_ex_bubble;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_ADVANCE = 7'b11111_00;
    localparam stage_ctrl_t CTRL_FREEZE  = 7'b00000_00;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational detection of the hazards forwarding cannot cover:
// load-use, branch-register and branch-flag dependencies.
import wisc_pipe_pkg::*;

module pipe_hazard_detect (
    input  logic [REG_W-1:0] i_if_id_rs,
    input  logic [REG_W-1:0] i_if_id_rt,
    input  logic             i_if_id_branch,
    input  logic             i_if_id_condbr,
    input  logic             i_if_id_store,
    input  logic [REG_W-1:0] i_id_ex_rd,
    input  logic             i_id_ex_write_reg,
    input  logic             i_id_ex_mem_read,
    input  logic             i_id_ex_flag_write,
    input  logic [REG_W-1:0] i_ex_mem_rd,
    input  logic             i_ex_mem_write_reg,
    output logic             o_lu,
    output logic             o_brh,
    output logic             o_fh
);

    logic w_ex_load;
    logic w_ex_hits_rs;
    logic w_mem_hits_rs;

    assign w_ex_load     = i_id_ex_mem_read & i_id_ex_write_reg & (i_id_ex_rd != '0);
    assign w_ex_hits_rs  = i_id_ex_write_reg & (i_id_ex_rd == i_if_id_rs);
    assign w_mem_hits_rs = i_ex_mem_write_reg & (i_ex_mem_rd == i_if_id_rs);

    // Store data (rt) is picked up later by the MEM-to-MEM forward, so it never stalls.
    assign o_lu  = w_ex_load & ((i_id_ex_rd == i_if_id_rs) |
                                ((i_id_ex_rd == i_if_id_rt) & ~i_if_id_store));
    assign o_brh = i_if_id_branch & (i_if_id_rs != '0) & (w_ex_hits_rs | w_mem_hits_rs);
    assign o_fh  = i_if_id_condbr & i_id_ex_flag_write;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer: hazard stalls, I/D miss-fill arbitration of the shared
// memory port, all stage enables, and saturating stall/miss performance counters.
import wisc_pipe_pkg::*;

module pipeline_stall_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [REG_W-1:0] i_if_id_rs,
    input  logic [REG_W-1:0] i_if_id_rt,
    input  logic             i_if_id_branch,
    input  logic             i_if_id_condbr,
    input  logic             i_if_id_store,
    input  logic             i_branch_taken,
    input  logic [REG_W-1:0] i_id_ex_rd,
    input  logic             i_id_ex_write_reg,
    input  logic             i_id_ex_mem_read,
    input  logic             i_id_ex_flag_write,
    input  logic [REG_W-1:0] i_ex_mem_rd,
    input  logic             i_ex_mem_write_reg,
    input  logic             i_icache_miss,
    input  logic             i_dcache_miss,
    input  logic             i_mem_done,
    output logic             o_pc_write,
    output logic             o_if_id_write,
    output logic             o_id_ex_write,
    output logic             o_ex_mem_write,
    output logic             o_mem_wb_write,
    output logic             o_if_id_flush,
    output logic             o_id_ex_bubble,
    output logic             o_icache_grant,
    output logic             o_dcache_grant,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_miss_cnt
);

    pipe_state_e      r_state;
    logic             r_d_pend;
    logic             r_igrant;
    logic             r_dgrant;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_miss_cnt;

    logic        w_lu, w_brh, w_fh, w_hs;
    stage_ctrl_t w_ctrl;

    pipe_hazard_detect u_haz (
        .i_if_id_rs        (i_if_id_rs),
        .i_if_id_rt        (i_if_id_rt),
        .i_if_id_branch    (i_if_id_branch),
        .i_if_id_condbr    (i_if_id_condbr),
        .i_if_id_store     (i_if_id_store),
        .i_id_ex_rd        (i_id_ex_rd),
        .i_id_ex_write_reg (i_id_ex_write_reg),
        .i_id_ex_mem_read  (i_id_ex_mem_read),
        .i_id_ex_flag_write(i_id_ex_flag_write),
        .i_ex_mem_rd       (i_ex_mem_rd),
        .i_ex_mem_write_reg(i_ex_mem_write_reg),
        .o_lu              (w_lu),
        .o_brh             (w_brh),
        .o_fh              (w_fh)
    );

    assign w_hs = (r_state == RUN) & (w_lu | w_brh | w_fh);

    // Priority: D-miss freeze > fill in progress > hazard stall > I-miss > taken branch.
    always_comb begin
        w_ctrl = CTRL_ADVANCE;
        if (!i_rst) begin
            if ((r_state == D_FILL) || i_dcache_miss) begin
                w_ctrl = CTRL_FREEZE;
            end else if (r_state == I_FILL) begin
                w_ctrl.pc_write    = i_branch_taken;
                w_ctrl.if_id_flush = 1'b1;
            end else if (w_hs) begin
                w_ctrl.pc_write     = 1'b0;
                w_ctrl.if_id_write  = 1'b0;
                w_ctrl.id_ex_bubble = 1'b1;
            end else if (i_icache_miss) begin
                w_ctrl.pc_write    = 1'b0;
                w_ctrl.if_id_flush = 1'b1;
            end else if (i_branch_taken) begin
                w_ctrl.if_id_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= RUN;
            r_d_pend <= 1'b0;
            r_igrant <= 1'b0;
            r_dgrant <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (i_dcache_miss) begin
                        r_state  <= D_FILL;
                        r_dgrant <= 1'b1;
                    end else if (i_icache_miss) begin
                        r_state  <= I_FILL;
                        r_igrant <= 1'b1;
                    end
                end
                D_FILL: begin
                    if (i_mem_done) begin
                        r_dgrant <= 1'b0;
                        if (i_icache_miss) begin
                            r_state  <= I_FILL;
                            r_igrant <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                I_FILL: begin
                    // A D-miss arriving mid I-fill waits; the fill is never preempted.
                    if (i_mem_done) begin
                        r_igrant <= 1'b0;
                        r_d_pend <= 1'b0;
                        if (r_d_pend || i_dcache_miss) begin
                            r_state  <= D_FILL;
                            r_dgrant <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end else if (i_dcache_miss) begin
                        r_d_pend <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= RUN;
                    r_igrant <= 1'b0;
                    r_dgrant <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
            r_miss_cnt  <= '0;
        end else begin
            if (w_hs && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if ((r_state != RUN) && (r_miss_cnt != {CNT_W{1'b1}}))
                r_miss_cnt <= r_miss_cnt + CNT_W'(1);
        end
    end

    assign o_pc_write     = w_ctrl.pc_write;
    assign o_if_id_write  = w_ctrl.if_id_write;
    assign o_id_ex_write  = w_ctrl.id_ex_write;
    assign o_ex_mem_write = w_ctrl.ex_mem_write;
    assign o_mem_wb_write = w_ctrl.mem_wb_write;
    assign o_if_id_flush  = w_ctrl.if_id_flush;
    assign o_id_ex_bubble = w_ctrl.id_ex_bubble;
    assign o_icache_grant = r_igrant;
    assign o_dcache_grant = r_dgrant;
    assign o_stall_cnt    = r_stall_cnt;
    assign o_miss_cnt     = r_miss_cnt;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed scenarios plus randomized traffic
// checked against a behavioural model of the stall/fill rules.
module tb_pipeline_stall_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] rs, rt, exrd, memrd;
    logic       br, condbr, store, taken, exwr, exmr, exfw, memwr, imiss, dmiss, done;
    logic       pcw, ifidw, idexw, exmemw, memwbw, flush, bubble, igrant, dgrant;
    logic [15:0] stall_cnt, miss_cnt;
    logic [6:0] obs;

    int n_chk = 0;
    int n_fail = 0;

    pipeline_stall_ctrl #(.CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_id_rs(rs), .i_if_id_rt(rt),
        .i_if_id_branch(br), .i_if_id_condbr(condbr), .i_if_id_store(store),
        .i_branch_taken(taken),
        .i_id_ex_rd(exrd), .i_id_ex_write_reg(exwr), .i_id_ex_mem_read(exmr),
        .i_id_ex_flag_write(exfw),
        .i_ex_mem_rd(memrd), .i_ex_mem_write_reg(memwr),
        .i_icache_miss(imiss), .i_dcache_miss(dmiss), .i_mem_done(done),
        .o_pc_write(pcw), .o_if_id_write(ifidw), .o_id_ex_write(idexw),
        .o_ex_mem_write(exmemw), .o_mem_wb_write(memwbw),
        .o_if_id_flush(flush), .o_id_ex_bubble(bubble),
        .o_icache_grant(igrant), .o_dcache_grant(dgrant),
        .o_stall_cnt(stall_cnt), .o_miss_cnt(miss_cnt)
    );

    assign obs = {pcw, ifidw, idexw, exmemw, memwbw, flush, bubble};

    // Reference model: who owns the memory port (0 none, 1 D, 2 I), a remembered
    // D request, and plain cycle tallies.
    int          mfill = 0;
    bit          mdpend = 1'b0;
    logic [15:0] ms = '0;
    logic [15:0] mm = '0;

    function automatic bit m_haz();
        bit ld  = exmr && exwr && (exrd != 0);
        bit lu  = ld && ((exrd == rs) || ((exrd == rt) && !store));
        bit brh = br && (rs != 0) && ((exwr && exrd == rs) || (memwr && memrd == rs));
        return lu || brh || (condbr && exfw);
    endfunction

    // Expected {pc, if_id, id_ex, ex_mem, mem_wb, flush, bubble}.
    function automatic logic [6:0] m_ctrl();
        if (rst) return 7'b1111100;
        if (mfill == 1 || dmiss) return 7'b0000000;
        if (mfill == 2) return {taken, 6'b111110};
        if (m_haz()) return 7'b0011101;
        if (imiss) return 7'b0111110;
        if (taken) return 7'b1111110;
        return 7'b1111100;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mfill <= 0; mdpend <= 1'b0; ms <= '0; mm <= '0;
        end else begin
            if (mfill == 0 && m_haz() && ms != 16'hFFFF) ms <= ms + 16'd1;
            if (mfill != 0 && mm != 16'hFFFF) mm <= mm + 16'd1;
            if (mfill == 0) begin
                if (dmiss) mfill <= 1;
                else if (imiss) mfill <= 2;
            end else if (mfill == 1) begin
                if (done) mfill <= imiss ? 2 : 0;
            end else begin
                if (done) begin
                    mfill  <= (mdpend || dmiss) ? 1 : 0;
                    mdpend <= 1'b0;
                end else if (dmiss) begin
                    mdpend <= 1'b1;
                end
            end
        end
    end

    task automatic clear_in();
        rs = 0; rt = 0; exrd = 0; memrd = 0;
        br = 0; condbr = 0; store = 0; taken = 0; exwr = 0; exmr = 0; exfw = 0;
        memwr = 0; imiss = 0; dmiss = 0; done = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_in();
        rst = 1'b1; dmiss = 1; condbr = 1; exfw = 1;
        half();
        n_chk++; if (obs !== 7'b1111100) begin n_fail++; $display("FAIL reset_comb got %b exp %b", obs, 7'b1111100); end
        cyc();
        rst = 1'b0; clear_in();
        half();
        n_chk++; if ({igrant, dgrant} !== 2'b00) begin n_fail++; $display("FAIL reset_grants got %b exp 00", {igrant, dgrant}); end
        n_chk++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); end
        n_chk++; if (miss_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_miss_cnt got %0d exp 0", miss_cnt); end
    endtask

    task automatic test_load_use();
        do_reset();
        exmr = 1; exwr = 1; exrd = 3; rs = 3; rt = 5;
        half();
        n_chk++; if (obs !== 7'b0011101) begin n_fail++; $display("FAIL lu_rs_stall got %b exp %b", obs, 7'b0011101); end
        cyc();
        exmr = 0; exwr = 0; exrd = 0;
        half();
        n_chk++; if (obs !== 7'b1111100) begin n_fail++; $display("FAIL lu_release got %b exp %b", obs, 7'b1111100); end
        n_chk++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_stall_cnt got %0d exp 1", stall_cnt); end
        exmr = 1; exwr = 1; exrd = 3; rs = 5; rt = 3;
        #1;
        n_chk++; if (obs !== 7'b0011101) begin n_fail++; $display("FAIL lu_rt_stall got %b exp %b", obs, 7'b0011101); end
    endtask

    task automatic test_no_false_stall();
        do_reset();
        exmr = 1; exwr = 1; exrd = 3; rs = 1; rt = 3; store = 1;
        half();
        n_chk++; if (obs !== 7'b1111100) begin n_fail++; $display("FAIL sw_rt_no_stall got %b exp %b", obs, 7'b1111100); end
        cyc();
        store = 0; exrd = 0; rs = 0; rt = 0;
        half();
        n_chk++; if (obs !== 7'b1111100) begin n_fail++; $display("FAIL r0_no_stall got %b exp %b", obs, 7'b1111100); end
        cyc();
        clear_in(); exfw = 1; br = 1; rs = 0; exwr = 1; exrd = 0;
        half();
        n_chk++; if (obs !== 7'b1111100) begin n_fail++; $display("FAIL br_r0_no_stall got %b exp %b", obs, 7'b1111100); end
        cyc();
        clear_in();
        half();
        n_chk++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL nofalse_stall_cnt got %0d exp 0", stall_cnt); end
    endtask

    task automatic test_branch_hazard();
        do_reset();
        br = 1; rs = 2; exwr = 1; exrd = 2;
        half();
        n_chk++; if (obs !== 7'b0011101) begin n_fail++; $display("FAIL brh_ex got %b exp %b", obs, 7'b0011101); end
        cyc();
        exwr = 0; exrd = 0; memwr = 1; memrd = 2;
        half();
        n_chk++; if (obs !== 7'b0011101) begin n_fail++; $display("FAIL brh_mem got %b exp %b", obs, 7'b0011101); end
        cyc();
        memwr = 0; memrd = 0; taken = 1;
        half();
        n_chk++; if (obs !== 7'b1111110) begin n_fail++; $display("FAIL br_taken_flush got %b exp %b", obs, 7'b1111110); end
        cyc();
        br = 0; condbr = 1; exfw = 1; taken = 1;
        half();
        n_chk++; if (obs !== 7'b0011101) begin n_fail++; $display("FAIL fh_ignores_taken got %b exp %b", obs, 7'b0011101); end
        cyc();
        clear_in();
        half();
        n_chk++; if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL brh_stall_cnt got %0d exp 3", stall_cnt); end
    endtask

    task automatic test_dmiss();
        do_reset();
        repeat (9) cyc();
        dmiss = 1;
        half();
        n_chk++; if (obs !== 7'b0000000) begin n_fail++; $display("FAIL dmiss_freeze got %b exp 0000000", obs); end
        n_chk++; if (dgrant !== 1'b0) begin n_fail++; $display("FAIL dmiss_grant_early got %b exp 0", dgrant); end
        cyc();
        half();
        n_chk++; if ({dgrant, obs} !== 8'b1_0000000) begin n_fail++; $display("FAIL dfill_grant got %b exp %b", {dgrant, obs}, 8'b1_0000000); end
        cyc(); cyc(); cyc();
        done = 1;
        half();
        n_chk++; if (dgrant !== 1'b1) begin n_fail++; $display("FAIL dfill_grant_at_done got %b exp 1", dgrant); end
        cyc();
        done = 0; dmiss = 0;
        half();
        n_chk++; if ({dgrant, obs} !== 8'b0_1111100) begin n_fail++; $display("FAIL dfill_release got %b exp %b", {dgrant, obs}, 8'b0_1111100); end
        n_chk++; if (miss_cnt !== 16'd4) begin n_fail++; $display("FAIL dfill_miss_cnt got %0d exp 4", miss_cnt); end
    endtask

    task automatic test_simul_miss();
        do_reset();
        imiss = 1; dmiss = 1;
        half();
        n_chk++; if (obs !== 7'b0000000) begin n_fail++; $display("FAIL both_freeze got %b exp 0000000", obs); end
        cyc();
        done = 1;
        half();
        n_chk++; if ({igrant, dgrant} !== 2'b01) begin n_fail++; $display("FAIL both_d_first got %b exp 01", {igrant, dgrant}); end
        cyc();
        done = 0; dmiss = 0; taken = 1;
        half();
        n_chk++; if ({igrant, dgrant, obs} !== 9'b10_1111110) begin n_fail++; $display("FAIL ifill_redirect got %b exp %b", {igrant, dgrant, obs}, 9'b10_1111110); end
        cyc();
        taken = 0; dmiss = 1;
        half();
        n_chk++; if (obs !== 7'b0000000) begin n_fail++; $display("FAIL ifill_dmiss_freeze got %b exp 0000000", obs); end
        cyc();
        dmiss = 0;
        half();
        n_chk++; if (obs !== 7'b0111110) begin n_fail++; $display("FAIL ifill_steady got %b exp %b", obs, 7'b0111110); end
        cyc();
        done = 1;
        half();
        n_chk++; if (igrant !== 1'b1) begin n_fail++; $display("FAIL ifill_grant_at_done got %b exp 1", igrant); end
        cyc();
        imiss = 0;
        half();
        n_chk++; if ({igrant, dgrant} !== 2'b01) begin n_fail++; $display("FAIL dpend_served got %b exp 01", {igrant, dgrant}); end
        cyc();
        done = 0;
        half();
        n_chk++; if ({igrant, dgrant, obs} !== 9'b00_1111100) begin n_fail++; $display("FAIL simul_back_to_run got %b exp %b", {igrant, dgrant, obs}, 9'b00_1111100); end
        n_chk++; if (miss_cnt !== 16'd6) begin n_fail++; $display("FAIL simul_miss_cnt got %0d exp 6", miss_cnt); end
    endtask

    task automatic test_reset_midfill();
        do_reset();
        dmiss = 1; condbr = 1; exfw = 1;
        cyc();
        half();
        n_chk++; if (dgrant !== 1'b1) begin n_fail++; $display("FAIL midfill_pre got %b exp 1", dgrant); end
        cyc();
        rst = 1'b1;
        half();
        n_chk++; if (obs !== 7'b1111100) begin n_fail++; $display("FAIL midfill_reset_comb got %b exp %b", obs, 7'b1111100); end
        cyc();
        rst = 1'b0; clear_in();
        half();
        n_chk++; if ({igrant, dgrant, stall_cnt, miss_cnt} !== 34'd0) begin n_fail++; $display("FAIL midfill_reset_state got g=%b%b s=%0d m=%0d exp all 0", igrant, dgrant, stall_cnt, miss_cnt); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            rst    = ($urandom_range(0, 99) == 0);
            rs     = 4'($urandom_range(0, 3));
            rt     = 4'($urandom_range(0, 3));
            exrd   = 4'($urandom_range(0, 3));
            memrd  = 4'($urandom_range(0, 3));
            br     = 1'($urandom_range(0, 1));
            condbr = ($urandom_range(0, 3) == 0);
            store  = 1'($urandom_range(0, 1));
            taken  = ($urandom_range(0, 3) == 0);
            exwr   = 1'($urandom_range(0, 1));
            exmr   = 1'($urandom_range(0, 1));
            exfw   = ($urandom_range(0, 3) == 0);
            memwr  = 1'($urandom_range(0, 1));
            imiss  = ($urandom_range(0, 6) == 0);
            dmiss  = ($urandom_range(0, 7) == 0);
            done   = ($urandom_range(0, 2) == 0);
            half();
            n_chk++;
            if ({obs, igrant, dgrant} !== {m_ctrl(), mfill == 2, mfill == 1}) begin
                n_fail++;
                $display("FAIL rand_ctrl it=%0d got %b exp %b", i, {obs, igrant, dgrant}, {m_ctrl(), mfill == 2, mfill == 1});
            end
            n_chk++;
            if ({stall_cnt, miss_cnt} !== {ms, mm}) begin
                n_fail++;
                $display("FAIL rand_cnt it=%0d got s=%0d m=%0d exp s=%0d m=%0d", i, stall_cnt, miss_cnt, ms, mm);
            end
            cyc();
        end
        rst = 1'b0;
        clear_in();
    endtask

    task automatic test_saturation();
        do_reset();
        condbr = 1; exfw = 1;
        repeat (65535) cyc();
        half();
        n_chk++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach got %h exp FFFF", stall_cnt); end
        cyc();
        half();
        n_chk++; if ({stall_cnt, obs} !== {16'hFFFF, 7'b0011101}) begin n_fail++; $display("FAIL sat_hold got %h/%b exp FFFF/%b", stall_cnt, obs, 7'b0011101); end
        cyc();
        clear_in();
    endtask

    initial begin
        clear_in();
        rst = 1'b0;
        test_reset();
        test_load_use();
        test_no_false_stall();
        test_branch_hazard();
        test_dmiss();
        test_simul_miss();
        test_reset_midfill();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
